// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry stereo buffer feeding a 32-slot serial frame.
// Ports: master_clk, rst (async low); bit_clk_en / sample_clk_en slot and frame
// strobes; sample_left/right/valid/ready handshake; bclk, lrclk, sdata to the
// DAC; underrun and frame_err one-cycle status pulses.
// Build option: define I2S_TX_LJ_EN for left-justified output instead of I2S.
module i2s_tx (
  input  logic        master_clk,
  input  logic        rst,
  input  logic        bit_clk_en,
  input  logic        sample_clk_en,
  input  logic [15:0] sample_left,
  input  logic [15:0] sample_right,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic        frame_err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        buf_full;
  logic [31:0] buf_word;
  logic [31:0] shift;
  logic [31:0] load_word;
  logic [4:0]  slot;
  logic [4:0]  slot_nx;
  logic [3:0]  phase;
  logic        accept;
  logic        advance;
  logic        lr_nx;
  logic        sd_nx;

  assign sample_ready = !buf_full;
  assign accept       = sample_valid && !buf_full;
  assign load_word    = buf_full ? buf_word : 32'd0;
  // frame starts always coincide with a slot strobe, so they advance too
  assign advance      = sample_clk_en ||
                        (state == RUN && bit_clk_en);

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    slot_nx  = sample_clk_en ? 5'd0 : slot + 5'd1;
    lr_nx    = 1'b0;
    sd_nx    = 1'b0;
    unique case (state)
      IDLE:    if (sample_clk_en) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase
`ifdef I2S_TX_LJ_EN
    lr_nx = !slot_nx[4];
    sd_nx = sample_clk_en ? load_word[31] : shift[~slot_nx];
`else
    // one-bit delay: slot 0 replays bit 0 of the outgoing word,
    // which is still zero after leaving IDLE since reset clears it
    lr_nx = slot_nx[4];
    sd_nx = shift[5'd0 - slot_nx];
`endif
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      buf_full  <= 1'b0;
      buf_word  <= '0;
      shift     <= '0;
      slot      <= '0;
      phase     <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      phase     <= bit_clk_en ? 4'd0 : phase + 4'd1;
      if (sample_clk_en) begin
        shift     <= load_word;
        underrun  <= !buf_full;
        frame_err <= (state == RUN) && (slot != 5'd31);
      end
      // a buffer drained by this frame start cannot also accept
      if (sample_clk_en && buf_full) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf_word <= {sample_left, sample_right};
      end
      if (advance) begin
        slot  <= slot_nx;
        lrclk <= lr_nx;
        sdata <= sd_nx;
        bclk  <= 1'b0;
      end else if (state == RUN && phase == 4'd7) begin
        bclk <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx against a slot-level reference model.
// Prints one summary line at the end.
module tb_i2s_tx;

  logic        master_clk = 1'b0;
  logic        rst = 1'b0;
  logic        bit_clk_en = 1'b0;
  logic        sample_clk_en = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;
  logic        frame_err;

  i2s_tx dut (
    .master_clk    (master_clk),
    .rst           (rst),
    .bit_clk_en    (bit_clk_en),
    .sample_clk_en (sample_clk_en),
    .sample_left   (sample_left),
    .sample_right  (sample_right),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .underrun      (underrun),
    .frame_err     (frame_err)
  );

  always #5 master_clk = ~master_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: frame/slot view of the stream
  bit          m_run = 0;
  bit          m_full = 0;
  bit [31:0]   m_buf = '0;
  bit [31:0]   m_word = '0;
  int          m_slot = 0;
  int          m_since = 100;
  bit          e_bclk = 0;
  bit          e_lr = 0;
  bit          e_sd = 0;
  bit          e_ur = 0;
  bit          e_fe = 0;
  bit          e_ready = 1;

  always @(posedge master_clk or negedge rst) begin
    bit acc;
    bit prev;
    if (!rst) begin
      m_run = 0; m_full = 0; m_buf = '0; m_word = '0;
      m_slot = 0; m_since = 100;
      e_bclk = 0; e_lr = 0; e_sd = 0;
      e_ur = 0; e_fe = 0; e_ready = 1;
    end else begin
      acc  = sample_valid && !m_full;
      e_ur = 0;
      e_fe = 0;
      if (bit_clk_en) m_since = 0;
      else if (m_since < 100) m_since++;
      if (sample_clk_en) begin
        e_fe = m_run && (m_slot != 31);
        prev = m_word[0];
        if (m_full) begin
          m_word = m_buf;
          m_full = 0;
        end else begin
          m_word = 0;
          e_ur = 1;
        end
        if (acc) begin
          m_buf  = {sample_left, sample_right};
          m_full = 1;
        end
        m_slot = 0;
        m_run  = 1;
`ifdef I2S_TX_LJ_EN
        e_lr = 1;
        e_sd = m_word[31];
`else
        e_lr = 0;
        e_sd = prev;
`endif
      end else begin
        if (acc) begin
          m_buf  = {sample_left, sample_right};
          m_full = 1;
        end
        if (m_run && bit_clk_en) begin
          m_slot = (m_slot + 1) % 32;
`ifdef I2S_TX_LJ_EN
          e_lr = m_slot < 16;
          e_sd = m_word[31 - m_slot];
`else
          e_lr = m_slot >= 16;
          e_sd = (m_slot == 0) ? m_word[0] : m_word[32 - m_slot];
`endif
        end
      end
      e_bclk  = m_run && (m_since >= 8);
      e_ready = !m_full;
    end
  end

  // stimulus state
  int       cnt = 0;
  int       mode = 0;
  bit       inj_req = 0;
  int       ur_cnt = 0;
  int       fe_cnt = 0;
  bit [15:0] seq = 16'h1000;

  task automatic tick();
    @(negedge master_clk);
    check("bclk", 32'(bclk), 32'(e_bclk));
    check("lrclk", 32'(lrclk), 32'(e_lr));
    check("sdata", 32'(sdata), 32'(e_sd));
    check("underrun", 32'(underrun), 32'(e_ur));
    check("frame_err", 32'(frame_err), 32'(e_fe));
    check("ready", 32'(sample_ready), 32'(e_ready));
    if (underrun) ur_cnt++;
    if (frame_err) fe_cnt++;
    if (inj_req && (cnt % 512 == 160)) begin
      cnt = 0;
      inj_req = 0;
    end
    bit_clk_en    = (cnt % 16 == 0);
    sample_clk_en = (cnt % 512 == 0);
    case (mode)
      1: begin
        sample_valid = ($urandom % 4) == 0;
        sample_left  = 16'($urandom);
        sample_right = 16'($urandom);
      end
      2: begin
        sample_valid = 1'b1;
        sample_left  = seq;
        sample_right = ~seq;
        if (sample_ready) seq++;
      end
      3: begin
        sample_valid = sample_clk_en;
        sample_left  = 16'($urandom);
        sample_right = 16'($urandom);
      end
      default: sample_valid = 1'b0;
    endcase
    cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    run(3);
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrclk", 32'(lrclk), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    @(negedge master_clk);
    rst = 1'b1;
    cnt = 5;

    // idle with enables running but no samples
    mode = 0;
    ur_cnt = 0;
    run(3 * 512);
    check("idle_underruns", 32'(ur_cnt), 32'd3);

    // one directed sample before the next frame
    while (cnt % 512 != 500) tick();
    @(negedge master_clk);
    sample_valid = 1'b1;
    sample_left  = 16'hA5C3;
    sample_right = 16'h0001;
    bit_clk_en    = (cnt % 16 == 0);
    sample_clk_en = 1'b0;
    cnt++;
    ur_cnt = 0;
    mode = 0;
    run(2 * 512);
    check("a5c3_underruns", 32'(ur_cnt), 32'd1);

    // continuous valid with incrementing data
    mode = 2;
    run(20);
    ur_cnt = 0;
    run(4 * 512);
    check("stream_underruns", 32'(ur_cnt), 32'd0);

    // valid only coincident with the frame strobe
    mode = 3;
    run(6 * 512);

    // extra frame strobe mid-frame
    mode = 1;
    fe_cnt = 0;
    inj_req = 1;
    run(3 * 512);
    check("frame_err_cnt", 32'(fe_cnt), 32'd1);

    // asynchronous reset mid-frame at slot 20
    while (cnt % 512 != 20 * 16 + 3) tick();
    rst = 1'b0;
    #1;
    check("arst_bclk", 32'(bclk), 32'd0);
    check("arst_lrclk", 32'(lrclk), 32'd0);
    check("arst_sdata", 32'(sdata), 32'd0);
    check("arst_ready", 32'(sample_ready), 32'd1);
    run(4);
    @(negedge master_clk);
    rst = 1'b1;
    run(3 * 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
